// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-digit display scan controller with blanking gap and frame-synchronous value update
module seg_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic [3:0] a1,
    output logic [3:0] a2,
    output logic       b,
    output logic [1:0] an,
    output logic       frame_tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;
    localparam logic [1:0] S_ENTRY = (BLANK == 0) ? S_SHOW : S_BLANK;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

    logic [1:0]    state, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          b_n, frame_start;
    logic [1:0]    an_n;
    logic [7:0]    pending, shadow;

    assign a1 = shadow[7:4];
    assign a2 = shadow[3:0];

    // Next scan state; a frame starts on scan entry and on every b 0->1 slot change
    always_comb begin
        st_n        = state;
        cnt_n       = cnt + 1'b1;
        b_n         = b;
        frame_start = 1'b0;
        if (!en) begin
            st_n  = S_IDLE;
            cnt_n = '0;
            b_n   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    st_n        = S_ENTRY;
                    cnt_n       = '0;
                    b_n         = 1'b1;
                    frame_start = 1'b1;
                end
                S_BLANK: st_n = (cnt == BLANK_LAST) ? S_SHOW : S_BLANK;
                S_SHOW: if (cnt == CNT_LAST) begin
                    st_n        = S_ENTRY;
                    cnt_n       = '0;
                    b_n         = ~b;
                    frame_start = ~b;
                end
                default: begin
                    st_n  = S_IDLE;
                    cnt_n = '0;
                    b_n   = 1'b1;
                end
            endcase
        end
        an_n = (st_n == S_SHOW) ? (b_n ? 2'b01 : 2'b10) : 2'b11;
    end

    // Register scan state and outputs; a load coinciding with frame start bypasses pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            b          <= 1'b1;
            an         <= 2'b11;
            frame_tick <= 1'b0;
            pending    <= '0;
            shadow     <= '0;
        end else begin
            state      <= st_n;
            cnt        <= cnt_n;
            b          <= b_n;
            an         <= an_n;
            frame_tick <= frame_start;
            if (load) pending <= data_in;
            if (frame_start) shadow <= load ? data_in : pending;
        end
    end
endmodule
